// File: rtl/mem_sequencer.sv
// mem_sequencer: owns the single port of the synapse/weight memory and
// time-shares it between the host bulk loader, the neuron-core scanner
// (valid/ready read-out stream) and single-entry learning updates.
module mem_sequencer #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    // host loader
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_done,
    // neuron-core scanner
    input  logic          scan_start,
    output logic          scan_valid,
    input  logic          scan_ready,
    output logic [DW-1:0] scan_data,
    output logic [AW-1:0] scan_addr,
    output logic          scan_last,
    // learning-unit updates
    input  logic          upd_req,
    input  logic [AW-1:0] upd_addr,
    input  logic [DW-1:0] upd_data,
    output logic          upd_gnt,
    // memory port
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD         = 2'd1,
        SCAN_FETCH   = 2'd2,
        SCAN_PRESENT = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_reg;
    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] scan_addr_reg;
    logic [DW-1:0] scan_data_reg;
    logic          load_done_reg;
    logic          scan_valid_reg;
    logic          busy_reg;

    // Sequencer state, address pointer and the registered stream/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            scan_addr_reg  <= '0;
            scan_data_reg  <= '0;
            load_done_reg  <= 1'b0;
            scan_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Starts outrank updates; an update that loses must be held.
                    if (load_start) begin
                        ptr_reg   <= '0;
                        state_reg <= LOAD;
                        busy_reg  <= 1'b1;
                    end else if (scan_start) begin
                        ptr_reg   <= '0;
                        state_reg <= SCAN_FETCH;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD: begin
                    // Gaps in load_valid simply stall the pointer.
                    if (load_valid) begin
                        ptr_reg <= ptr_reg + 1'b1;
                        if (ptr_reg == LAST_ADDR) begin
                            state_reg     <= IDLE;
                            busy_reg      <= 1'b0;
                            load_done_reg <= 1'b1;
                        end
                    end
                end
                SCAN_FETCH: begin
                    // Capture the entry so a later write to it cannot disturb
                    // the value being presented.
                    scan_data_reg  <= mem_rdata;
                    scan_addr_reg  <= ptr_reg;
                    scan_valid_reg <= 1'b1;
                    state_reg      <= SCAN_PRESENT;
                end
                SCAN_PRESENT: begin
                    if (scan_ready) begin
                        scan_valid_reg <= 1'b0;
                        if (scan_addr_reg == LAST_ADDR) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            ptr_reg   <= ptr_reg + 1'b1;
                            state_reg <= SCAN_FETCH;
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    scan_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux and update grant; forced quiet while reset is asserted.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        upd_gnt   = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (!load_start && !scan_start && upd_req) begin
                        upd_gnt   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = upd_addr;
                        mem_wdata = upd_data;
                    end
                end
                LOAD: begin
                    mem_addr  = ptr_reg;
                    mem_wdata = load_data;
                    mem_we    = load_valid;
                end
                SCAN_FETCH: begin
                    mem_addr = ptr_reg;
                end
                SCAN_PRESENT: begin
                    // Port is idle while the consumer holds the entry.
                    if (upd_req) begin
                        upd_gnt   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = upd_addr;
                        mem_wdata = upd_data;
                    end
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    assign load_done  = load_done_reg;
    assign scan_valid = scan_valid_reg;
    assign scan_data  = scan_data_reg;
    assign scan_addr  = scan_addr_reg;
    assign scan_last  = scan_valid_reg && (scan_addr_reg == LAST_ADDR);
    assign busy       = busy_reg;

endmodule
